// File: rtl/bus_grant_encoder_pkg.sv
// Shared definitions for the bus grant encoder: requester count and FSM encoding.
package bus_grant_pkg;

    localparam int unsigned N_REQ = 8;
    localparam int unsigned IDX_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/bus_grant_encoder_rr_pick.sv
// Round-robin search: first set request bit at or after ptr, wrapping modulo N_REQ.
module rr_pick
    import bus_grant_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             hit,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] pos;

    // Scan from the farthest offset down so the nearest set bit wins.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        pos = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            pos = ptr + IDX_W'(k);
            if (req[pos]) begin
                hit = 1'b1;
                idx = pos;
            end
        end
    end

endmodule

// File: rtl/bus_grant_encoder.sv
// Round-robin bus arbiter: holds one grant until done or a timeout forces release.
module bus_grant_encoder
    import bus_grant_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_sel,
    output logic [N_REQ-1:0] grant_onehot,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state, state_nxt;
    logic [IDX_W-1:0] ptr, ptr_nxt;
    logic [IDX_W-1:0] sel_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             timeout_nxt;
    logic             pick_hit;
    logic [IDX_W-1:0] pick_idx;

    rr_pick u_rr_pick (
        .req (req),
        .ptr (ptr),
        .hit (pick_hit),
        .idx (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= '0;
            grant_sel   <= '0;
            cnt         <= '0;
            grant_valid <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            state       <= state_nxt;
            ptr         <= ptr_nxt;
            grant_sel   <= sel_nxt;
            cnt         <= cnt_nxt;
            grant_valid <= (state_nxt == GRANT);
            timeout     <= timeout_nxt;
        end
    end

    // Done outranks the timeout check; the release cycle always lands in IDLE.
    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        sel_nxt     = grant_sel;
        cnt_nxt     = cnt;
        timeout_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (pick_hit) begin
                    state_nxt = GRANT;
                    sel_nxt   = pick_idx;
                    cnt_nxt   = '0;
                end
            end
            GRANT: begin
                if (done) begin
                    state_nxt = IDLE;
                    ptr_nxt   = grant_sel + IDX_W'(1);
                end else if (cnt == CNT_LAST) begin
                    state_nxt   = IDLE;
                    ptr_nxt     = grant_sel + IDX_W'(1);
                    timeout_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        grant_onehot = '0;
        if (grant_valid) begin
            grant_onehot[grant_sel] = 1'b1;
        end
    end

endmodule

// File: tb/tb_bus_grant_encoder.sv
// Self-checking bench for bus_grant_encoder: directed vector table, corner sequences, random vs model.
module tb_bus_grant_encoder;

    localparam int unsigned TO = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] req;
    logic       done;
    logic       grant_valid;
    logic [2:0] grant_sel;
    logic [7:0] grant_onehot;
    logic       timeout;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: grant holder, next-search pointer, grant cycles elapsed.
    bit m_gv;
    int m_sel;
    int m_ptr;
    int m_age;
    bit m_to;

    typedef struct {
        bit       rst;
        bit [7:0] r;
        bit       d;
        bit       gv;
        bit [2:0] sel;
        bit [7:0] oh;
        bit       to;
    } vec_t;

    vec_t vecs[30];

    always #5 clk = ~clk;

    bus_grant_encoder #(.TIMEOUT(TO), .CNT_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .done         (done),
        .grant_valid  (grant_valid),
        .grant_sel    (grant_sel),
        .grant_onehot (grant_onehot),
        .timeout      (timeout)
    );

    function automatic vec_t mk(bit rst, bit [7:0] r, bit d, bit gv, bit [2:0] sel, bit [7:0] oh, bit to);
        vec_t v;
        v.rst = rst; v.r = r; v.d = d; v.gv = gv; v.sel = sel; v.oh = oh; v.to = to;
        return v;
    endfunction

    function automatic int first_from(bit [7:0] r, int p);
        for (int k = 0; k < 8; k++) begin
            if (r[(p + k) % 8]) return (p + k) % 8;
        end
        return -1;
    endfunction

    task automatic model_step(bit rst, bit [7:0] r, bit d);
        m_to = 1'b0;
        if (rst) begin
            m_gv = 1'b0; m_sel = 0; m_ptr = 0; m_age = 0;
        end else if (!m_gv) begin
            if (r != 8'h00) begin
                m_sel = first_from(r, m_ptr);
                m_gv  = 1'b1;
                m_age = 1;
            end
        end else if (d) begin
            m_gv  = 1'b0;
            m_ptr = (m_sel + 1) % 8;
        end else if (m_age == int'(TO)) begin
            m_gv  = 1'b0;
            m_ptr = (m_sel + 1) % 8;
            m_to  = 1'b1;
        end else begin
            m_age++;
        end
    endtask

    task automatic apply(bit rst, bit [7:0] r, bit d);
        reset = rst;
        req   = r;
        done  = d;
        @(posedge clk);
        model_step(rst, r, d);
        #1;
    endtask

    task automatic check(string name, bit gv, bit [2:0] sel, bit [7:0] oh, bit to);
        n_tests++;
        if (grant_valid !== gv || grant_sel !== sel || grant_onehot !== oh || timeout !== to) begin
            n_fail++;
            $display("FAIL %s: got gv=%0b sel=%0d oh=%h to=%0b, expected gv=%0b sel=%0d oh=%h to=%0b",
                     name, grant_valid, grant_sel, grant_onehot, timeout, gv, sel, oh, to);
        end
    endtask

    task automatic check_model(string name);
        bit [7:0] oh;
        oh = m_gv ? 8'(1 << m_sel) : 8'h00;
        check(name, m_gv, 3'(m_sel), oh, m_to);
    endtask

    initial begin
        bit [7:0] r;
        bit       rst;
        bit       d;

        reset = 1'b1; req = 8'h00; done = 1'b0;

        vecs[0]  = mk(1, 8'h00, 0, 0, 0, 8'h00, 0);
        vecs[1]  = mk(0, 8'h04, 0, 1, 2, 8'h04, 0);
        vecs[2]  = mk(0, 8'h00, 1, 0, 2, 8'h00, 0);
        vecs[3]  = mk(0, 8'hFF, 0, 1, 3, 8'h08, 0);
        vecs[4]  = mk(0, 8'hFF, 1, 0, 3, 8'h00, 0);
        vecs[5]  = mk(0, 8'h20, 0, 1, 5, 8'h20, 0);
        vecs[6]  = mk(0, 8'h00, 1, 0, 5, 8'h00, 0);
        vecs[7]  = mk(0, 8'h03, 0, 1, 0, 8'h01, 0);
        vecs[8]  = mk(0, 8'h03, 1, 0, 0, 8'h00, 0);
        vecs[9]  = mk(0, 8'h03, 0, 1, 1, 8'h02, 0);
        vecs[10] = mk(0, 8'h00, 1, 0, 1, 8'h00, 0);
        vecs[11] = mk(0, 8'h10, 0, 1, 4, 8'h10, 0);
        vecs[12] = mk(0, 8'h00, 0, 1, 4, 8'h10, 0);
        vecs[13] = mk(0, 8'h00, 0, 1, 4, 8'h10, 0);
        vecs[14] = mk(0, 8'h00, 0, 1, 4, 8'h10, 0);
        vecs[15] = mk(0, 8'h00, 0, 0, 4, 8'h00, 1);
        vecs[16] = mk(0, 8'h00, 0, 0, 4, 8'h00, 0);
        vecs[17] = mk(0, 8'hFF, 0, 1, 5, 8'h20, 0);
        vecs[18] = mk(0, 8'hFF, 0, 1, 5, 8'h20, 0);
        vecs[19] = mk(0, 8'hFF, 0, 1, 5, 8'h20, 0);
        vecs[20] = mk(0, 8'hFF, 0, 1, 5, 8'h20, 0);
        vecs[21] = mk(0, 8'h00, 1, 0, 5, 8'h00, 0);
        vecs[22] = mk(0, 8'h00, 0, 0, 5, 8'h00, 0);
        vecs[23] = mk(0, 8'h80, 0, 1, 7, 8'h80, 0);
        vecs[24] = mk(1, 8'hFF, 1, 0, 0, 8'h00, 0);
        vecs[25] = mk(0, 8'hFF, 0, 1, 0, 8'h01, 0);
        vecs[26] = mk(1, 8'h00, 0, 0, 0, 8'h00, 0);
        vecs[27] = mk(0, 8'h00, 1, 0, 0, 8'h00, 0);
        vecs[28] = mk(0, 8'h02, 1, 1, 1, 8'h02, 0);
        vecs[29] = mk(0, 8'h00, 1, 0, 1, 8'h00, 0);

        for (int i = 0; i < 30; i++) begin
            apply(vecs[i].rst, vecs[i].r, vecs[i].d);
            check($sformatf("vec%0d", i), vecs[i].gv, vecs[i].sel, vecs[i].oh, vecs[i].to);
        end

        // Fairness: all requesting, done on every grant -> 0..7,0 every other cycle.
        apply(1, 8'h00, 0);
        check("fair_reset", 0, 0, 8'h00, 0);
        for (int k = 0; k < 9; k++) begin
            apply(0, 8'hFF, 0);
            check($sformatf("fair_grant%0d", k), 1, 3'(k % 8), 8'(1 << (k % 8)), 0);
            apply(0, 8'hFF, 1);
            check($sformatf("fair_rel%0d", k), 0, 3'(k % 8), 8'h00, 0);
        end

        // Stability: req churns during a grant on index 5.
        apply(1, 8'h00, 0);
        apply(0, 8'h20, 0);
        check("stab_entry", 1, 5, 8'h20, 0);
        for (int k = 0; k < 2; k++) begin
            apply(0, 8'($urandom), 0);
            check($sformatf("stab_hold%0d", k), 1, 5, 8'h20, 0);
        end
        apply(0, 8'($urandom), 1);
        check("stab_done", 0, 5, 8'h00, 0);

        // Random traffic against the reference model.
        apply(1, 8'h00, 0);
        check_model("rand_reset");
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 63) == 0);
            r   = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00;
            d   = ($urandom_range(0, 2) == 0);
            apply(rst, r, d);
            check_model($sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
